// File: rtl/arb88_pkg.sv
// Shared types and widths for the 8088 memory-port arbiter.
package arb88_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_B   = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter88_if.sv
// Requester and memory-side signals of the shared 8-bit memory port.
interface mem_arbiter88_if;

    logic        cpu_req;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_wreq;
    logic [7:0]  cpu_bus;
    logic        cpu_locked;

    logic        b_req;
    logic [19:0] b_address;
    logic [7:0]  b_wdata;
    logic        b_we;
    logic [7:0]  b_rdata;
    logic        b_ack;

    logic [19:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_address, cpu_data, cpu_wreq,
        input  b_req, b_address, b_wdata, b_we,
        input  mem_rdata,
        output cpu_bus, cpu_locked, b_rdata, b_ack,
        output mem_address, mem_wdata, mem_we
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_address, cpu_data, cpu_wreq,
        output b_req, b_address, b_wdata, b_we,
        output mem_rdata,
        input  cpu_bus, cpu_locked, b_rdata, b_ack,
        input  mem_address, mem_wdata, mem_we
    );

endinterface

// File: rtl/arb88_pick.sv
// B-priority grant decision with a CPU anti-starvation burst counter.
module arb88_pick
    import arb88_pkg::*;
#(
    parameter int unsigned B_BURST_MAX = 4
) (
    input  logic   clock,
    input  logic   resetn,
    input  logic   cpu_req,
    input  logic   b_req,
    input  logic   grant_en,
    output logic   grant_valid,
    output grant_t grant_sel
);

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(B_BURST_MAX);

    logic [CNT_W-1:0] burst_q, burst_d;

    // Port B wins unless the CPU has waited through BURST_LIMIT B grants
    always_comb begin
        grant_valid = cpu_req | b_req;
        grant_sel   = GNT_CPU;
        if (b_req && !(cpu_req && (burst_q == BURST_LIMIT))) begin
            grant_sel = GNT_B;
        end
    end

    // Count B grants that bypassed a waiting CPU; any other grant clears
    always_comb begin
        burst_d = burst_q;
        if (grant_en && grant_valid) begin
            if (grant_sel == GNT_CPU) begin
                burst_d = '0;
            end else if (cpu_req) begin
                burst_d = (burst_q == BURST_LIMIT) ? burst_q : burst_q + CNT_W'(1);
            end else begin
                burst_d = '0;
            end
        end
    end

    // Burst counter register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/mem_arbiter88.sv
// Shares one 8-bit memory port between the 8088 core and port B,
// inserting wait states and returning a one-cycle completion strobe.
module mem_arbiter88
    import arb88_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned B_BURST_MAX = 4
) (
    input  logic             clock,
    input  logic             resetn,
    mem_arbiter88_if.slave   bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    grant_t           grant_q, grant_d;
    logic [19:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [7:0]       cpu_bus_q, cpu_bus_d;
    logic [7:0]       b_rdata_q, b_rdata_d;
    logic             locked_q, locked_d;
    logic             ack_q, ack_d;

    logic             grant_en;
    logic             grant_valid;
    grant_t           grant_sel;

    assign grant_en = (state_q == ST_IDLE);

    arb88_pick #(
        .B_BURST_MAX (B_BURST_MAX)
    ) u_pick (
        .clock       (clock),
        .resetn      (resetn),
        .cpu_req     (bus.cpu_req),
        .b_req       (bus.b_req),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    // Next-state and datapath decode; address/data hold unless a new grant is made
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        cpu_bus_d = cpu_bus_q;
        b_rdata_d = b_rdata_q;
        locked_d  = 1'b0;
        ack_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    grant_d = grant_sel;
                    if (grant_sel == GNT_B) begin
                        addr_d  = bus.b_address;
                        wdata_d = bus.b_wdata;
                        we_d    = bus.b_we;
                    end else begin
                        addr_d  = bus.cpu_address;
                        wdata_d = bus.cpu_data;
                        we_d    = bus.cpu_wreq;
                    end
                    wait_d  = CNT_W'(WAIT_STATES);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wait_q == '0) begin
                    if (!we_q) begin
                        if (grant_q == GNT_CPU) cpu_bus_d = bus.mem_rdata;
                        else                    b_rdata_d = bus.mem_rdata;
                    end
                    if (grant_q == GNT_CPU) locked_d = 1'b1;
                    else                    ack_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            grant_q   <= GNT_CPU;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cpu_bus_q <= '0;
            b_rdata_q <= '0;
            locked_q  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cpu_bus_q <= cpu_bus_d;
            b_rdata_q <= b_rdata_d;
            locked_q  <= locked_d;
            ack_q     <= ack_d;
        end
    end

    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_we      = (state_q == ST_ACCESS) && (wait_q == '0) && we_q;
    assign bus.cpu_bus     = cpu_bus_q;
    assign bus.cpu_locked  = locked_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.b_ack       = ack_q;

endmodule

// File: tb/tb_mem_arbiter88.sv
// Directed bench for mem_arbiter88 at WAIT_STATES 1 (main), 0 and 3.
module tb_mem_arbiter88;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter88_if bus1 ();
    mem_arbiter88_if bus0 ();
    mem_arbiter88_if bus3 ();

    mem_arbiter88 #(.WAIT_STATES(1), .B_BURST_MAX(4)) u_ws1 (
        .clock (clock), .resetn (resetn), .bus (bus1));
    mem_arbiter88 #(.WAIT_STATES(0), .B_BURST_MAX(4)) u_ws0 (
        .clock (clock), .resetn (resetn), .bus (bus0));
    mem_arbiter88 #(.WAIT_STATES(3), .B_BURST_MAX(4)) u_ws3 (
        .clock (clock), .resetn (resetn), .bus (bus3));

    logic [7:0] mem [0:1048575];

    assign bus1.mem_rdata = mem[bus1.mem_address];
    assign bus0.mem_rdata = mem[bus0.mem_address];
    assign bus3.mem_rdata = mem[bus3.mem_address];

    always @(posedge clock) begin
        if (bus1.mem_we) mem[bus1.mem_address] <= bus1.mem_wdata;
    end

    int tests = 0;
    int fails = 0;

    int          we_cnt = 0, locked_cnt = 0, ack_cnt = 0, overlap_cnt = 0;
    logic [19:0] we_addr = '0;
    logic [7:0]  we_data = '0;
    bit          log_en = 1'b0;
    int          order [$];

    always @(negedge clock) begin
        if (bus1.mem_we === 1'b1) begin
            we_cnt  = we_cnt + 1;
            we_addr = bus1.mem_address;
            we_data = bus1.mem_wdata;
        end
        if (bus1.cpu_locked === 1'b1) locked_cnt = locked_cnt + 1;
        if (bus1.b_ack === 1'b1) ack_cnt = ack_cnt + 1;
        if (bus1.cpu_locked === 1'b1 && bus1.b_ack === 1'b1) overlap_cnt = overlap_cnt + 1;
        if (log_en && bus1.cpu_locked === 1'b1) order.push_back(0);
        if (log_en && bus1.b_ack === 1'b1) order.push_back(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input bit is_b, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if ((is_b ? bus1.b_ack : bus1.cpu_locked) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_cpu_bus"},  {24'd0, bus1.cpu_bus},     32'h0);
        check({pfx, "_locked"},   {31'd0, bus1.cpu_locked},  32'h0);
        check({pfx, "_b_rdata"},  {24'd0, bus1.b_rdata},     32'h0);
        check({pfx, "_b_ack"},    {31'd0, bus1.b_ack},       32'h0);
        check({pfx, "_mem_addr"}, {12'd0, bus1.mem_address}, 32'h0);
        check({pfx, "_mem_wdata"},{24'd0, bus1.mem_wdata},   32'h0);
        check({pfx, "_mem_we"},   {31'd0, bus1.mem_we},      32'h0);
    endtask

    task automatic idle_inputs();
        bus1.cpu_req = 0; bus1.cpu_address = '0; bus1.cpu_data = '0; bus1.cpu_wreq = 0;
        bus1.b_req = 0;   bus1.b_address = '0;   bus1.b_wdata = '0;  bus1.b_we = 0;
        bus0.cpu_req = 0; bus0.cpu_address = '0; bus0.cpu_data = '0; bus0.cpu_wreq = 0;
        bus0.b_req = 0;   bus0.b_address = '0;   bus0.b_wdata = '0;  bus0.b_we = 0;
        bus3.cpu_req = 0; bus3.cpu_address = '0; bus3.cpu_data = '0; bus3.cpu_wreq = 0;
        bus3.b_req = 0;   bus3.b_address = '0;   bus3.b_wdata = '0;  bus3.b_we = 0;
    endtask

    initial begin
        int n, f0, f3, fa, fl;
        int s_we, s_lk, s_ack, s_ov;

        idle_inputs();
        mem[20'hF0000] = 8'hEA;
        mem[20'hB8000] = 8'h00;
        mem[20'h00100] = 8'hA5;
        mem[20'h00200] = 8'h5A;
        mem[20'h12345] = 8'h3C;
        mem[20'h0ABCD] = 8'h00;

        // Reset state
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        check_outputs_zero("rst");
        resetn = 1'b1;
        @(negedge clock);

        // CPU read, WAIT_STATES=1
        bus1.cpu_address = 20'hF0000; bus1.cpu_wreq = 0; bus1.cpu_req = 1;
        @(negedge clock);
        check("cpu_rd_addr", {12'd0, bus1.mem_address}, 32'hF0000);
        wait_strobe(1'b0, n);
        check("cpu_rd_latency", n, 2);
        check("cpu_rd_data", {24'd0, bus1.cpu_bus}, 32'hEA);
        bus1.cpu_req = 0;
        @(negedge clock);
        check("cpu_rd_strobe_clear", {31'd0, bus1.cpu_locked}, 32'h0);
        #1;
        check("cpu_rd_no_we", we_cnt, 0);
        check("cpu_rd_one_strobe", locked_cnt, 1);

        // B write
        s_we = we_cnt; s_lk = locked_cnt; s_ack = ack_cnt;
        bus1.b_address = 20'hB8000; bus1.b_wdata = 8'h41; bus1.b_we = 1; bus1.b_req = 1;
        wait_strobe(1'b1, n);
        check("b_wr_latency", n, 3);
        bus1.b_req = 0; bus1.b_we = 0;
        repeat (2) @(negedge clock);
        #1;
        check("b_wr_we_pulses", we_cnt - s_we, 1);
        check("b_wr_we_addr", {12'd0, we_addr}, 32'hB8000);
        check("b_wr_we_data", {24'd0, we_data}, 32'h41);
        check("b_wr_ack_pulses", ack_cnt - s_ack, 1);
        check("b_wr_no_locked", locked_cnt - s_lk, 0);
        check("b_wr_mem", {24'd0, mem[20'hB8000]}, 32'h41);

        // Both requesters held: expect B,B,B,B,CPU repeating
        @(negedge clock);
        s_ov = overlap_cnt;
        order.delete();
        bus1.cpu_address = 20'h00100; bus1.cpu_wreq = 0;
        bus1.b_address = 20'h00200; bus1.b_we = 0;
        bus1.cpu_req = 1; bus1.b_req = 1;
        log_en = 1'b1;
        repeat (40) @(negedge clock);
        bus1.cpu_req = 0; bus1.b_req = 0;
        repeat (2) @(negedge clock);
        #1;
        log_en = 1'b0;
        check("burst_count", order.size(), 10);
        for (int i = 0; i < 10 && i < order.size(); i++) begin
            check($sformatf("burst_grant%0d", i), order[i], (i % 5 == 4) ? 0 : 1);
        end
        check("burst_overlap", overlap_cnt - s_ov, 0);
        check("burst_cpu_data", {24'd0, bus1.cpu_bus}, 32'hA5);
        check("burst_b_data", {24'd0, bus1.b_rdata}, 32'h5A);

        // WAIT_STATES 0 and 3; data taken from the final ACCESS cycle
        @(negedge clock);
        bus0.cpu_address = 20'h12345; bus0.cpu_req = 1;
        bus3.cpu_address = 20'h12345; bus3.cpu_req = 1;
        f0 = -1; f3 = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 3) mem[20'h12345] = 8'hC3;
            if (bus0.cpu_locked === 1'b1 && f0 < 0) begin f0 = i; bus0.cpu_req = 0; end
            if (bus3.cpu_locked === 1'b1 && f3 < 0) begin f3 = i; bus3.cpu_req = 0; end
        end
        bus0.cpu_req = 0; bus3.cpu_req = 0;
        check("ws0_latency", f0, 2);
        check("ws3_latency", f3, 5);
        check("ws0_data", {24'd0, bus0.cpu_bus}, 32'h3C);
        check("ws3_data", {24'd0, bus3.cpu_bus}, 32'hC3);

        // Reset during the first ACCESS cycle of a B write
        s_we = we_cnt; s_ack = ack_cnt;
        bus1.b_address = 20'h0ABCD; bus1.b_wdata = 8'h77; bus1.b_we = 1; bus1.b_req = 1;
        @(negedge clock);
        resetn = 1'b0;
        bus1.b_req = 0; bus1.b_we = 0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check_outputs_zero("post_rst");
        #1;
        check("rst_abort_no_we", we_cnt - s_we, 0);
        check("rst_abort_no_ack", ack_cnt - s_ack, 0);
        check("rst_abort_mem", {24'd0, mem[20'h0ABCD]}, 32'h00);
        bus1.cpu_address = 20'hF0000; bus1.cpu_wreq = 0; bus1.cpu_req = 1;
        wait_strobe(1'b0, n);
        check("post_rst_latency", n, 3);
        check("post_rst_data", {24'd0, bus1.cpu_bus}, 32'hEA);
        bus1.cpu_req = 0;
        @(negedge clock);

        // b_req dropped mid-access while the CPU waits
        s_ack = ack_cnt;
        bus1.cpu_address = 20'h00100; bus1.cpu_wreq = 0;
        bus1.b_address = 20'h00200; bus1.b_we = 0;
        bus1.cpu_req = 1; bus1.b_req = 1;
        fa = -1; fl = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (i == 1) bus1.b_req = 0;
            if (bus1.b_ack === 1'b1 && fa < 0) fa = i;
            if (bus1.cpu_locked === 1'b1 && fl < 0) begin fl = i; bus1.cpu_req = 0; end
        end
        bus1.cpu_req = 0;
        #1;
        check("bdrop_ack_at", fa, 3);
        check("bdrop_cpu_at", fl, 7);
        check("bdrop_ack_once", ack_cnt - s_ack, 1);
        check("bdrop_b_data", {24'd0, bus1.b_rdata}, 32'h5A);
        check("bdrop_cpu_data", {24'd0, bus1.cpu_bus}, 32'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
